cmp_scan_ctrl: RTL and testbench

- Sequencer that scans a block of N words from a register-file/memory read port, using the shared unsigned 32-bit compare unit, and returns the maximum or minimum word and its index.
- Drives the compare unit's A/B operand buses and consumes its 2-bit result code (00 equal, 01 A>B, 10 A<B).
- Sits between the lab3 datapath's compare unit and a single registered read port.
- Processes one element per cycle once the pipeline fills.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/cmp_scan_addr_gen.sv | 57 +++++
 rtl/cmp_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_cmp_scan_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg : shared compare-unit result codes, scan modes and scan FSM states.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/cmp_scan_addr_gen.sv
// ---------------------------------------------------------------------------
// cmp_scan_addr_gen : issue counter, wrapping read address and read strobe.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmp_scan_addr_gen #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_count,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_i;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;

  // Index 0 is issued on the load edge itself, so r_i counts words already issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_count   <= '0;
      r_i       <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else if (i_load) begin
      r_base    <= i_base;
      r_count   <= i_count;
      r_i       <= CNT_W'(1);
      r_rd_en   <= 1'b1;
      r_rd_addr <= i_base;
    end else if (r_rd_en) begin
      if (r_i == r_count) begin
        r_rd_en <= 1'b0;
      end else begin
        r_rd_addr <= r_base + r_i[ADDR_W-1:0];
        r_i       <= r_i + CNT_W'(1);
      end
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_last    = r_rd_en && (r_i == r_count);

endmodule

`default_nettype wire

// File: rtl/cmp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// cmp_scan_ctrl : scans N words through the external compare unit, max or min.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmp_scan_ctrl
  import cmp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic [1:0]        cmp_result,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] best_value,
  output logic [ADDR_W-1:0] best_index,
  output logic              empty
);

  scan_state_e       r_state;
  logic              r_mode;
  logic              r_v;
  logic [CNT_W-1:0]  r_j;
  logic              r_busy;
  logic              r_done;
  logic              r_empty;
  logic [DATA_W-1:0] r_best_value;
  logic [ADDR_W-1:0] r_best_index;

  logic w_load;
  logic w_last;
  logic w_cmp_active;
  logic w_upd;

  assign w_load = (r_state == S_IDLE) && start && (count != '0);

  cmp_scan_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_base    (base_addr),
    .i_count   (count),
    .o_rd_en   (rd_en),
    .o_rd_addr (rd_addr),
    .o_last    (w_last)
  );

  assign w_cmp_active = r_v && (r_j != '0);
  assign cmp_a        = w_cmp_active ? rd_data : '0;
  assign cmp_b        = r_best_value;

  // Strict comparisons only: ties and the reserved code keep the earlier winner.
  assign w_upd = ((r_mode == MODE_MAX) && (cmp_result == CMP_GT)) ||
                 ((r_mode == MODE_MIN) && (cmp_result == CMP_LT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_MAX;
      r_v          <= 1'b0;
      r_j          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_empty      <= 1'b0;
      r_best_value <= '0;
      r_best_index <= '0;
    end else begin
      r_done <= 1'b0;
      r_v    <= rd_en;

      if (r_v) begin
        if (r_j == '0) begin
          r_best_value <= rd_data;
          r_best_index <= '0;
        end else if (w_upd) begin
          r_best_value <= rd_data;
          r_best_index <= r_j[ADDR_W-1:0];
        end
        r_j <= r_j + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_mode  <= mode;
              r_empty <= 1'b0;
              r_busy  <= 1'b1;
              r_j     <= '0;
              r_state <= S_READ;
            end else begin
              r_empty      <= 1'b1;
              r_best_value <= '0;
              r_best_index <= '0;
              r_done       <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (w_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign empty      = r_empty;
  assign best_value = r_best_value;
  assign best_index = r_best_index;

endmodule

`default_nettype wire

// File: tb/tb_cmp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmp_scan_ctrl : scoreboard bench with memory and compare-unit models.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cmp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [1:0]  cmp_result;
  logic        busy;
  logic        done;
  logic [31:0] best_value;
  logic [4:0]  best_index;
  logic        empty;

  logic [31:0] mem [0:31];

  typedef struct {
    logic [31:0] v;
    logic [4:0]  i;
    logic        e;
    int          cyc;
    int          e0;
  } exp_t;

  exp_t       sb[$];
  exp_t       x;
  logic [4:0] rd_log[$];
  int errors   = 0;
  int checks   = 0;
  int ecnt     = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  cmp_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .base_addr  (base_addr),
    .count      (count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_result (cmp_result),
    .busy       (busy),
    .done       (done),
    .best_value (best_value),
    .best_index (best_index),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always_comb begin
    cmp_result = 2'b10;
    if (cmp_a == cmp_b) cmp_result = 2'b00;
    else if (cmp_a > cmp_b) cmp_result = 2'b01;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en) rd_log.push_back(rd_addr);
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk("best_value", best_value, x.v);
        chk("best_index", {27'd0, best_index}, {27'd0, x.i});
        chk("empty", {31'd0, empty}, {31'd0, x.e});
        chk("done_cycle", 32'(ecnt - x.e0 + 1), 32'(x.cyc));
      end
    end
  end

  task automatic wait_done(input int target);
    for (int k = 0; k < 200 && done_cnt < target; k++) @(posedge clk);
    chk("done_seen", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic run_scan(input logic m, input logic [4:0] b, input logic [5:0] n,
                          input logic [31:0] ev, input logic [4:0] ei, input logic ee);
    int   target;
    exp_t e;
    @(negedge clk);
    mode = m; base_addr = b; count = n; start = 1'b1;
    rd_log.delete();
    busy_cnt = 0;
    target = done_cnt + 1;
    @(posedge clk);
    #1 start = 1'b0;
    e.v = ev; e.i = ei; e.e = ee;
    e.cyc = (n == 6'd0) ? 1 : int'(n) + 2;
    e.e0 = ecnt;
    sb.push_back(e);
    wait_done(target);
    chk("busy_cycles", 32'(busy_cnt), (n == 6'd0) ? 32'd0 : 32'(n) + 32'd1);
    chk("rd_en_cycles", 32'(rd_log.size()), 32'(n));
  endtask

  initial begin
    int   dc;
    exp_t e;
    logic [4:0] wrap_exp [0:3];
    wrap_exp[0] = 5'd30; wrap_exp[1] = 5'd31; wrap_exp[2] = 5'd0; wrap_exp[3] = 5'd1;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; count = '0;
    for (int k = 0; k < 32; k++) mem[k] = 32'hDEAD_0000 + 32'(k);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset_outputs", {rd_en, busy, done, empty, rd_addr, best_index},  16'h0000);
    chk("reset_best_value", best_value, 32'd0);

    // max scan, duplicate max keeps first index
    mem[4] = 32'd5; mem[5] = 32'd9; mem[6] = 32'd3; mem[7] = 32'd9;
    run_scan(1'b0, 5'd4, 6'd4, 32'd9, 5'd1, 1'b0);
    run_scan(1'b1, 5'd4, 6'd4, 32'd3, 5'd2, 1'b0);

    // min scan across the address wrap
    mem[30] = 32'd7; mem[31] = 32'd2; mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd2;
    run_scan(1'b1, 5'd30, 6'd4, 32'd2, 5'd1, 1'b0);
    for (int k = 0; k < 4; k++)
      chk("wrap_addr", (k < rd_log.size()) ? {27'd0, rd_log[k]} : 32'hFFFF_FFFF, {27'd0, wrap_exp[k]});

    run_scan(1'b0, 5'd3, 6'd0, 32'd0, 5'd0, 1'b1);

    mem[10] = 32'h8000_0000;
    run_scan(1'b1, 5'd10, 6'd1, 32'h8000_0000, 5'd0, 1'b0);

    // asynchronous reset in the middle of an 8-word scan
    @(negedge clk);
    mode = 1'b0; base_addr = 5'd0; count = 6'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {rd_en, busy, done, empty, rd_addr, best_index}, 16'h0000);
    chk("midreset_best_value", best_value, 32'd0);
    chk("midreset_cmp_a", cmp_a, 32'd0);
    dc = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(posedge clk);
    chk("midreset_no_done", 32'(done_cnt), 32'(dc));

    // start held high through two full 32-word scans
    for (int k = 0; k < 32; k++) mem[k] = 32'(31 - k);
    @(negedge clk);
    mode = 1'b0; base_addr = 5'd0; count = 6'd32; start = 1'b1;
    dc = done_cnt;
    @(posedge clk);
    #1;
    e.v = 32'd31; e.i = 5'd0;  e.e = 1'b0; e.cyc = 34; e.e0 = ecnt; sb.push_back(e);
    e.v = 32'd0;  e.i = 5'd31; e.e = 1'b0; e.cyc = 69;               sb.push_back(e);
    wait_done(dc + 1);
    #1 mode = 1'b1;
    wait_done(dc + 2);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    chk("held_start_scans", 32'(done_cnt - dc), 32'd2);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
